// File: rtl/config_bus_arb_if.sv
// OCP configuration-slave signal bundle shared by the bridge and its bus master.
interface config_bus_arb_if #(
  parameter int DATA_W = 32
);
  logic [2:0]          ocp_MCmd;
  logic [31:0]         ocp_MAddr;
  logic [DATA_W-1:0]   ocp_MData;
  logic [DATA_W/8-1:0] ocp_MByteEn;
  logic                ocp_MRespAccept;
  logic                ocp_SCmdAccept;
  logic [1:0]          ocp_SResp;
  logic [DATA_W-1:0]   ocp_SData;

  modport master (
    output ocp_MCmd, ocp_MAddr, ocp_MData, ocp_MByteEn, ocp_MRespAccept,
    input  ocp_SCmdAccept, ocp_SResp, ocp_SData
  );

  modport slave (
    input  ocp_MCmd, ocp_MAddr, ocp_MData, ocp_MByteEn, ocp_MRespAccept,
    output ocp_SCmdAccept, ocp_SResp, ocp_SData
  );
endinterface

// File: rtl/config_bus_arb.sv
// Configuration-bus bridge: OCP slave and local config-unit master share one bank port,
// one access in flight, local side has priority, with wait-state timeout and error responses.
module config_bus_arb #(
  parameter int N_BANKS = 5,
  parameter int BANK_W  = 3,
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset_n,
  config_bus_arb_if.slave            ocp,
  input  logic                       supervisor,
  input  logic                       config_unit_en,
  input  logic                       config_unit_wr,
  input  logic [ADDR_W-1:0]          config_unit_addr,
  input  logic [DATA_W-1:0]          config_unit_wdata,
  output logic                       config_unit_ack,
  output logic                       config_unit_err,
  output logic                       config_en,
  output logic                       config_wr,
  output logic [ADDR_W-1:0]          config_addr,
  output logic [DATA_W-1:0]          config_wdata,
  output logic [N_BANKS-1:0]         bank_sel,
  input  logic [N_BANKS-1:0]         bank_ready,
  input  logic [N_BANKS-1:0]         bank_error,
  input  logic [N_BANKS*DATA_W-1:0]  bank_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] LOC  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [BANK_W:0]  NB_LIMIT = (BANK_W + 1)'(N_BANKS);

  logic [1:0]        state;
  logic [CNT_W-1:0]  tcnt;
  logic              cur_rd;
  logic [1:0]        sresp;
  logic [DATA_W-1:0] sdata;

  logic [2:0]        ocp_cmd;
  logic [ADDR_W-1:0] ocp_word;
  logic [BANK_W-1:0] ocp_bank;
  logic [BANK_W-1:0] loc_bank;
  logic              ocp_bad;
  logic              ready_hit;
  logic              error_hit;
  logic              timed_out;
  logic              loc_done;
  logic [DATA_W-1:0] rdata_hit;
  logic              unused_addr;

  function automatic logic mapped(input logic [BANK_W-1:0] id);
    return {1'b0, id} < NB_LIMIT;
  endfunction

  function automatic logic [N_BANKS-1:0] decode(input logic [BANK_W-1:0] id);
    logic [N_BANKS-1:0] sel;
    for (int i = 0; i < N_BANKS; i++) sel[i] = (id == BANK_W'(i));
    return sel;
  endfunction

  assign ocp_cmd     = ocp.ocp_MCmd;
  assign ocp_word    = ocp.ocp_MAddr[ADDR_W+1:2];
  assign ocp_bank    = ocp_word[ADDR_W-1 -: BANK_W];
  assign loc_bank    = config_unit_addr[ADDR_W-1 -: BANK_W];
  assign unused_addr = ^{ocp.ocp_MAddr[31:ADDR_W+2], ocp.ocp_MAddr[1:0]};

  // Rejected up front: no strobe ever reaches a bank for these.
  assign ocp_bad = !mapped(ocp_bank)
                || (ocp_cmd != CMD_WR && ocp_cmd != CMD_RD)
                || (ocp_cmd == CMD_WR && (!supervisor || !(&ocp.ocp_MByteEn)));

  assign ready_hit = |(bank_ready & bank_sel);
  assign error_hit = |(bank_error & bank_sel);
  assign timed_out = (TIMEOUT != 0) && (tcnt == CNT_LAST);

  always_comb begin
    rdata_hit = '0;
    for (int i = 0; i < N_BANKS; i++)
      if (bank_sel[i]) rdata_hit = rdata_hit | bank_rdata[i*DATA_W +: DATA_W];
  end

  // In LOC a cleared strobe means the local address was unmapped.
  assign loc_done        = (state == LOC) && (!config_en || ready_hit || timed_out);
  assign config_unit_ack = loc_done;
  assign config_unit_err = loc_done && (!config_en || !ready_hit || error_hit);

  assign ocp.ocp_SCmdAccept = (state == IDLE) && !config_unit_en && (ocp_cmd != CMD_IDLE);
  assign ocp.ocp_SResp      = sresp;
  assign ocp.ocp_SData      = sdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      tcnt         <= '0;
      cur_rd       <= 1'b0;
      config_en    <= 1'b0;
      config_wr    <= 1'b0;
      config_addr  <= '0;
      config_wdata <= '0;
      bank_sel     <= '0;
      sresp        <= RESP_NULL;
      sdata        <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (config_unit_en) begin
            state <= LOC;
            if (mapped(loc_bank)) begin
              config_en    <= 1'b1;
              config_wr    <= config_unit_wr;
              config_addr  <= config_unit_addr;
              config_wdata <= config_unit_wdata;
              bank_sel     <= decode(loc_bank);
            end
          end else if (ocp_cmd != CMD_IDLE) begin
            cur_rd <= (ocp_cmd == CMD_RD);
            if (ocp_bad) begin
              state <= RESP;
              sresp <= RESP_ERR;
              sdata <= '0;
            end else begin
              state        <= BUS;
              config_en    <= 1'b1;
              config_wr    <= (ocp_cmd == CMD_WR);
              config_addr  <= ocp_word;
              config_wdata <= ocp.ocp_MData;
              bank_sel     <= decode(ocp_bank);
            end
          end
        end
        BUS: begin
          if (ready_hit || timed_out) begin
            state     <= RESP;
            tcnt      <= '0;
            sresp     <= (ready_hit && !error_hit) ? RESP_DVA : RESP_ERR;
            sdata     <= (ready_hit && cur_rd) ? rdata_hit : '0;
            config_en <= 1'b0;
            config_wr <= 1'b0;
            bank_sel  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        LOC: begin
          if (loc_done) begin
            state     <= IDLE;
            tcnt      <= '0;
            config_en <= 1'b0;
            config_wr <= 1'b0;
            bank_sel  <= '0;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (ocp.ocp_MRespAccept) begin
            state <= IDLE;
            sresp <= RESP_NULL;
            sdata <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_bus_arb.sv
// Directed bench for config_bus_arb: OCP responses and local acks are predicted into
// scoreboard queues when issued and checked when the bridge produces them.
module tb_config_bus_arb;
  localparam int N_BANKS = 5;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 14;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [1:0] DVA      = 2'b01;
  localparam logic [1:0] ERR      = 2'b11;

  localparam logic [31:0] WORD0 = 32'h11110000;
  localparam logic [31:0] WORD1 = 32'h22221111;
  localparam logic [31:0] WORD2 = 32'hCAFE0001;
  localparam logic [31:0] WORD3 = 32'hDEAD0003;
  localparam logic [31:0] WORD4 = 32'h55554444;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset_n;
  logic                      supervisor;
  logic                      config_unit_en;
  logic                      config_unit_wr;
  logic [ADDR_W-1:0]         config_unit_addr;
  logic [DATA_W-1:0]         config_unit_wdata;
  logic                      config_unit_ack;
  logic                      config_unit_err;
  logic                      config_en;
  logic                      config_wr;
  logic [ADDR_W-1:0]         config_addr;
  logic [DATA_W-1:0]         config_wdata;
  logic [N_BANKS-1:0]        bank_sel;
  logic [N_BANKS-1:0]        bank_ready;
  logic [N_BANKS-1:0]        bank_error;
  logic [N_BANKS*DATA_W-1:0] bank_rdata;
  logic [N_BANKS-1:0]        ready_mask;
  logic [N_BANKS-1:0]        error_mask;

  int   vectors     = 0;
  int   miscompares = 0;
  int   en_total    = 0;
  exp_t resp_q[$];
  logic loc_q[$];

  config_bus_arb_if #(.DATA_W(DATA_W)) ocp ();

  config_bus_arb #(
    .N_BANKS(N_BANKS), .BANK_W(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ocp              (ocp),
    .supervisor       (supervisor),
    .config_unit_en   (config_unit_en),
    .config_unit_wr   (config_unit_wr),
    .config_unit_addr (config_unit_addr),
    .config_unit_wdata(config_unit_wdata),
    .config_unit_ack  (config_unit_ack),
    .config_unit_err  (config_unit_err),
    .config_en        (config_en),
    .config_wr        (config_wr),
    .config_addr      (config_addr),
    .config_wdata     (config_wdata),
    .bank_sel         (bank_sel),
    .bank_ready       (bank_ready),
    .bank_error       (bank_error),
    .bank_rdata       (bank_rdata)
  );

  // Bank model: selected banks answer in the strobe cycle unless masked off.
  assign bank_ready = config_en ? (bank_sel & ready_mask) : '0;
  assign bank_error = config_en ? (bank_sel & error_mask) : '0;
  assign bank_rdata = {WORD4, WORD3, WORD2, WORD1, WORD0};

  always @(posedge clk) if (config_en) en_total <= en_total + 1;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one OCP command, checks acceptance, then clocks the accepting edge.
  task automatic applyStimulus(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
    cyc();
    ocp.ocp_MCmd    = cmd;
    ocp.ocp_MAddr   = addr;
    ocp.ocp_MData   = data;
    ocp.ocp_MByteEn = be;
    #1;
    checkOutput({tag, "_accept"}, ocp.ocp_SCmdAccept, 1);
    cyc();
    ocp.ocp_MCmd = CMD_IDLE;
  endtask

  task automatic wait_resp(input string tag, input int budget, input int holds);
    int   n = 0;
    exp_t e;
    while (ocp.ocp_SResp == 2'b00 && n < budget) begin
      cyc();
      n++;
    end
    checkOutput({tag, "_resp_seen"}, ocp.ocp_SResp != 2'b00, 1);
    if (resp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s_scoreboard: observed empty queue, expected a pending response", tag);
    end else begin
      e = resp_q.pop_front();
      checkOutput({tag, "_sresp"}, ocp.ocp_SResp, e.resp);
      checkOutput({tag, "_sdata"}, ocp.ocp_SData, e.data);
      for (int i = 0; i < holds; i++) begin
        cyc();
        checkOutput({tag, "_hold"}, ocp.ocp_SResp, e.resp);
      end
    end
    ocp.ocp_MRespAccept = 1'b1;
    cyc();
    ocp.ocp_MRespAccept = 1'b0;
    checkOutput({tag, "_clear"}, ocp.ocp_SResp, 0);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int   n = 0;
    logic e;
    while (!config_unit_ack && n < budget) begin
      cyc();
      n++;
    end
    checkOutput({tag, "_ack_seen"}, config_unit_ack, 1);
    if (loc_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s_scoreboard: observed empty queue, expected a pending ack", tag);
    end else begin
      e = loc_q.pop_front();
      checkOutput({tag, "_err"}, config_unit_err, e);
    end
    config_unit_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          en_start;
    logic [1:0]  resp_or;

    reset_n             = 1'b0;
    supervisor          = 1'b1;
    config_unit_en      = 1'b0;
    config_unit_wr      = 1'b0;
    config_unit_addr    = '0;
    config_unit_wdata   = '0;
    ready_mask          = '1;
    error_mask          = '0;
    ocp.ocp_MCmd        = CMD_IDLE;
    ocp.ocp_MAddr       = '0;
    ocp.ocp_MData       = '0;
    ocp.ocp_MByteEn     = '0;
    ocp.ocp_MRespAccept = 1'b0;

    cyc(3);
    checkOutput("rst_sresp", ocp.ocp_SResp, 0);
    checkOutput("rst_sdata", ocp.ocp_SData, 0);
    checkOutput("rst_accept", ocp.ocp_SCmdAccept, 0);
    checkOutput("rst_en", config_en, 0);
    checkOutput("rst_sel", bank_sel, 0);
    checkOutput("rst_ack", config_unit_ack, 0);
    reset_n = 1'b1;

    // Read bank 2, bank answers in the strobe cycle.
    resp_q.push_back('{DVA, WORD2});
    applyStimulus("rd_b2", CMD_RD, 32'h0000_4004, 32'h0, 4'hF);
    checkOutput("rd_b2_en", config_en, 1);
    checkOutput("rd_b2_sel", bank_sel, 5'b00100);
    checkOutput("rd_b2_addr", config_addr, 14'h1001);
    checkOutput("rd_b2_wr", config_wr, 0);
    wait_resp("rd_b2", 10, 1);

    // Unmapped bank 6: error without strobe, held until accepted.
    en_start = en_total;
    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("wr_b6", CMD_WR, 32'h0000_C000, 32'hAAAA5555, 4'hF);
    checkOutput("wr_b6_en", config_en, 0);
    wait_resp("wr_b6", 10, 3);
    checkOutput("wr_b6_no_strobe", en_total - en_start, 0);

    // Bank 5 is the first unmapped index; bank 4 the last mapped.
    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("rd_b5", CMD_RD, 32'h0000_A000, 32'h0, 4'hF);
    wait_resp("rd_b5", 10, 0);
    resp_q.push_back('{DVA, WORD4});
    applyStimulus("rd_b4", CMD_RD, 32'h0000_8000, 32'h0, 4'hF);
    checkOutput("rd_b4_sel", bank_sel, 5'b10000);
    wait_resp("rd_b4", 10, 0);

    // Write without supervisor rights never reaches a bank.
    supervisor = 1'b0;
    en_start   = en_total;
    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("wr_user", CMD_WR, 32'h0000_2014, 32'h12345678, 4'hF);
    wait_resp("wr_user", 10, 0);
    checkOutput("wr_user_no_strobe", en_total - en_start, 0);

    supervisor = 1'b1;
    resp_q.push_back('{DVA, 32'h0});
    applyStimulus("wr_sup", CMD_WR, 32'h0000_2014, 32'h12345678, 4'hF);
    checkOutput("wr_sup_wr", config_wr, 1);
    checkOutput("wr_sup_wdata", config_wdata, 32'h12345678);
    checkOutput("wr_sup_addr", config_addr, 14'h0805);
    wait_resp("wr_sup", 10, 0);

    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("wr_partial_be", CMD_WR, 32'h0000_2014, 32'h12345678, 4'b0111);
    wait_resp("wr_partial_be", 10, 0);

    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("illegal_cmd", 3'b100, 32'h0000_4004, 32'h0, 4'hF);
    wait_resp("illegal_cmd", 10, 0);

    // Bank error qualifies ready; read data still returned.
    error_mask = 5'b01000;
    resp_q.push_back('{ERR, WORD3});
    applyStimulus("rd_b3_err", CMD_RD, 32'h0000_6000, 32'h0, 4'hF);
    wait_resp("rd_b3_err", 10, 0);
    error_mask = '0;

    // Silent bank: strobe held for exactly 15 cycles before the forced error.
    ready_mask = '0;
    en_start   = en_total;
    resp_q.push_back('{ERR, 32'h0});
    applyStimulus("timeout", CMD_RD, 32'h0000_0040, 32'h0, 4'hF);
    wait_resp("timeout", 40, 1);
    checkOutput("timeout_en_cycles", en_total - en_start, 15);
    ready_mask = '1;

    // Local request and OCP read in the same idle cycle: local goes first.
    cyc();
    config_unit_en   = 1'b1;
    config_unit_wr   = 1'b0;
    config_unit_addr = 14'h0810;
    ocp.ocp_MCmd     = CMD_RD;
    ocp.ocp_MAddr    = 32'h0000_4004;
    ocp.ocp_MByteEn  = 4'hF;
    #1;
    checkOutput("prio_ocp_stalled", ocp.ocp_SCmdAccept, 0);
    loc_q.push_back(1'b0);
    resp_q.push_back('{DVA, WORD2});
    cyc();
    checkOutput("prio_loc_en", config_en, 1);
    checkOutput("prio_loc_sel", bank_sel, 5'b00010);
    checkOutput("prio_loc_addr", config_addr, 14'h0810);
    wait_ack("prio_loc", 10);
    cyc();
    checkOutput("prio_ocp_accept", ocp.ocp_SCmdAccept, 1);
    cyc();
    ocp.ocp_MCmd = CMD_IDLE;
    checkOutput("prio_ocp_sel", bank_sel, 5'b00100);
    wait_resp("prio_ocp", 10, 0);

    // Local write to bank 4, then an unmapped local address.
    cyc();
    config_unit_en    = 1'b1;
    config_unit_wr    = 1'b1;
    config_unit_addr  = 14'h2005;
    config_unit_wdata = 32'hA5A5A5A5;
    loc_q.push_back(1'b0);
    cyc();
    checkOutput("loc_wr_wr", config_wr, 1);
    checkOutput("loc_wr_wdata", config_wdata, 32'hA5A5A5A5);
    wait_ack("loc_wr", 10);
    cyc();
    config_unit_en   = 1'b1;
    config_unit_wr   = 1'b0;
    config_unit_addr = 14'h3800;
    loc_q.push_back(1'b1);
    cyc();
    checkOutput("loc_unmapped_en", config_en, 0);
    wait_ack("loc_unmapped", 10);
    cyc();

    // Reset while a bank is stalling: everything drops, nothing stale follows.
    ready_mask = '0;
    applyStimulus("rst_mid", CMD_RD, 32'h0000_0040, 32'h0, 4'hF);
    cyc(3);
    checkOutput("rst_mid_en_before", config_en, 1);
    reset_n = 1'b0;
    cyc();
    checkOutput("rst_mid_en", config_en, 0);
    checkOutput("rst_mid_sel", bank_sel, 0);
    checkOutput("rst_mid_wr", config_wr, 0);
    checkOutput("rst_mid_sresp", ocp.ocp_SResp, 0);
    checkOutput("rst_mid_sdata", ocp.ocp_SData, 0);
    checkOutput("rst_mid_accept", ocp.ocp_SCmdAccept, 0);
    reset_n  = 1'b1;
    en_start = en_total;
    resp_or  = 2'b00;
    for (int i = 0; i < 20; i++) begin
      cyc();
      resp_or = resp_or | ocp.ocp_SResp;
    end
    checkOutput("rst_mid_no_stale_resp", resp_or, 0);
    checkOutput("rst_mid_no_strobe", en_total - en_start, 0);
    ready_mask = '1;

    resp_q.push_back('{DVA, WORD2});
    applyStimulus("recover", CMD_RD, 32'h0000_4004, 32'h0, 4'hF);
    wait_resp("recover", 10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
